// File: rtl/bc_io_intr_ctrl.sv
// ============================================================================
// bc_io_intr_ctrl
// ----------------------------------------------------------------------------
// I/O and interrupt sequencer for the basic computer.
//
// Owns the input/output flag handshakes (FGI, FGO), the INPR/OUTR character
// registers, the interrupt-enable flip-flop (IEN) and the interrupt
// flip-flop (R). Decodes the register-reference I/O instructions handed over
// by the main controller and, at instruction boundaries, runs the three-step
// interrupt cycle RT0..RT2 that saves PC at address 0 and vectors to 1.
//
// Configuration macro: BC_OUTPUT_PORT_EN
//   defined   : OUTR, FGO, OUT and SKO are implemented; FGI|FGO arms R.
//   undefined : FGO held 0, out_valid=0, out_data=0, OUT/SKO are NOPs,
//               out_ack ignored, only FGI arms R.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   io_exec        in   one-cycle I/O-instruction execute pulse (D7.I.T3)
//   ir_low         in   IR[11:0], valid while io_exec=1
//   instr_done     in   one-cycle end-of-instruction pulse
//   ac_low         in   AC[CHAR_W-1:0], source for OUT
//   in_valid       in   input device strobe
//   in_data        in   input character
//   in_ready       out  ~FGI
//   out_valid      out  ~FGO
//   out_data       out  OUTR
//   out_ack        in   output device consumed OUTR
//   inpr           out  INPR, for the AC load
//   ac_inpr_ld     out  load AC[CHAR_W-1:0] <- INPR (INP)
//   pc_inc         out  increment PC (skip taken or RT2)
//   int_active     out  R; the controller must not fetch while high
//   irq_ar_clr     out  RT0: AR <- 0
//   irq_tr_ld_pc   out  RT0: TR <- PC
//   irq_mem_wr_tr  out  RT1: M[AR] <- TR
//   irq_pc_clr     out  RT1: PC <- 0
//   irq_sc_clr     out  RT2: SC <- 0
//   ien            out  IEN flip-flop
// ============================================================================
module bc_io_intr_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12,
    parameter int CHAR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_exec,
    input  logic [11:0]       ir_low,
    input  logic              instr_done,
    input  logic [CHAR_W-1:0] ac_low,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_data,
    input  logic              out_ack,
    output logic [CHAR_W-1:0] inpr,
    output logic              ac_inpr_ld,
    output logic              pc_inc,
    output logic              int_active,
    output logic              irq_ar_clr,
    output logic              irq_tr_ld_pc,
    output logic              irq_mem_wr_tr,
    output logic              irq_pc_clr,
    output logic              irq_sc_clr,
    output logic              ien
);

    // The character registers sit in the low bits of AC and the I/O opcode
    // field is IR[11:0]; anything else is an unusable configuration.
    if (CHAR_W > WIDTH || CHAR_W < 1 || ADDR_W < 1) begin : g_cfg_invalid
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RT0  = 2'd1,
        S_RT1  = 2'd2,
        S_RT2  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              fgi_q, fgi_d;
    logic              fgo_q, fgo_d;
    logic              ien_q, ien_d;
    logic              r_q, r_d;
    logic [CHAR_W-1:0] inpr_q, inpr_d;
    logic [CHAR_W-1:0] outr_q, outr_d;

    logic io_ok;
    logic op_inp, op_out, op_ski, op_sko, op_ion, op_iof;
    logic arm_src;

    // IR[5:0] carries no I/O meaning; ac_low/out_ack are unused when the
    // output port is compiled out.
    logic unused_inputs;
    assign unused_inputs = ^{ir_low[5:0], ac_low, out_ack};

    // ------------------------------------------------------------------
    // Next-state, flag updates and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fgi_d         = fgi_q;
        fgo_d         = fgo_q;
        ien_d         = ien_q;
        r_d           = r_q;
        inpr_d        = inpr_q;
        outr_d        = outr_q;
        ac_inpr_ld    = 1'b0;
        pc_inc        = 1'b0;
        irq_ar_clr    = 1'b0;
        irq_tr_ld_pc  = 1'b0;
        irq_mem_wr_tr = 1'b0;
        irq_pc_clr    = 1'b0;
        irq_sc_clr    = 1'b0;

        // An I/O execute pulse arriving during the interrupt cycle is a
        // controller fault and is dropped.
        io_ok  = io_exec && (state_q == S_IDLE);
        op_inp = io_ok && ir_low[11];
        op_ski = io_ok && ir_low[9];
        op_ion = io_ok && ir_low[7];
        op_iof = io_ok && ir_low[6];
`ifdef BC_OUTPUT_PORT_EN
        op_out = io_ok && ir_low[10];
        op_sko = io_ok && ir_low[8];
`else
        op_out = 1'b0;
        op_sko = 1'b0;
`endif

        // Input side: INP clears FGI and wins over a simultaneous device
        // strobe, so the character is only taken while nothing is reading.
        if (in_valid && !fgi_q && !op_inp) begin
            fgi_d  = 1'b1;
            inpr_d = in_data;
        end
        if (op_inp) begin
            fgi_d      = 1'b0;
            ac_inpr_ld = 1'b1;
        end

`ifdef BC_OUTPUT_PORT_EN
        // Output side: OUT clears FGO and wins over a simultaneous ack.
        if (out_ack && !fgo_q) begin
            fgo_d = 1'b1;
        end
        if (op_out) begin
            fgo_d  = 1'b0;
            outr_d = ac_low;
        end
        arm_src = fgi_q || fgo_q;
`else
        fgo_d   = 1'b0;
        outr_d  = '0;
        arm_src = fgi_q;
`endif

        if (op_ski && fgi_q) begin
            pc_inc = 1'b1;
        end
        if (op_sko && fgo_q) begin
            pc_inc = 1'b1;
        end

        // IOF has priority over ION when both bits are set.
        if (op_ion) begin
            ien_d = 1'b1;
        end
        if (op_iof) begin
            ien_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Registered IEN is used, so an ION only takes effect at
                // the boundary after the following instruction.
                if (instr_done && ien_q && arm_src) begin
                    r_d     = 1'b1;
                    state_d = S_RT0;
                end
            end
            S_RT0: begin
                irq_ar_clr   = 1'b1;
                irq_tr_ld_pc = 1'b1;
                state_d      = S_RT1;
            end
            S_RT1: begin
                irq_mem_wr_tr = 1'b1;
                irq_pc_clr    = 1'b1;
                state_d       = S_RT2;
            end
            S_RT2: begin
                pc_inc     = 1'b1;
                irq_sc_clr = 1'b1;
                ien_d      = 1'b0;
                r_d        = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Nothing is allowed to reach the datapath while reset is asserted.
        if (!rst_n) begin
            ac_inpr_ld    = 1'b0;
            pc_inc        = 1'b0;
            irq_ar_clr    = 1'b0;
            irq_tr_ld_pc  = 1'b0;
            irq_mem_wr_tr = 1'b0;
            irq_pc_clr    = 1'b0;
            irq_sc_clr    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fgi_q   <= 1'b0;
`ifdef BC_OUTPUT_PORT_EN
            fgo_q   <= 1'b1;
`else
            fgo_q   <= 1'b0;
`endif
            ien_q   <= 1'b0;
            r_q     <= 1'b0;
            inpr_q  <= '0;
            outr_q  <= '0;
        end else begin
            state_q <= state_d;
            fgi_q   <= fgi_d;
            fgo_q   <= fgo_d;
            ien_q   <= ien_d;
            r_q     <= r_d;
            inpr_q  <= inpr_d;
            outr_q  <= outr_d;
        end
    end

    assign in_ready   = ~fgi_q;
    assign inpr       = inpr_q;
    assign ien        = ien_q;
    assign int_active = r_q;
`ifdef BC_OUTPUT_PORT_EN
    assign out_valid  = ~fgo_q;
    assign out_data   = outr_q;
`else
    assign out_valid  = 1'b0;
    assign out_data   = '0;
`endif

endmodule

// File: tb/tb_bc_io_intr_ctrl.sv
module tb_bc_io_intr_ctrl;

    localparam int CHAR_W = 8;
`ifdef BC_OUTPUT_PORT_EN
    localparam bit OUTEN = 1'b1;
`else
    localparam bit OUTEN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              io_exec;
    logic [11:0]       ir_low;
    logic              instr_done;
    logic [CHAR_W-1:0] ac_low;
    logic              in_valid;
    logic [CHAR_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [CHAR_W-1:0] out_data;
    logic              out_ack;
    logic [CHAR_W-1:0] inpr;
    logic              ac_inpr_ld;
    logic              pc_inc;
    logic              int_active;
    logic              irq_ar_clr, irq_tr_ld_pc, irq_mem_wr_tr, irq_pc_clr, irq_sc_clr;
    logic              ien;

    bc_io_intr_ctrl #(.WIDTH(16), .ADDR_W(12), .CHAR_W(CHAR_W)) dut (
        .clk(clk), .rst_n(rst_n), .io_exec(io_exec), .ir_low(ir_low),
        .instr_done(instr_done), .ac_low(ac_low), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ack(out_ack), .inpr(inpr),
        .ac_inpr_ld(ac_inpr_ld), .pc_inc(pc_inc), .int_active(int_active),
        .irq_ar_clr(irq_ar_clr), .irq_tr_ld_pc(irq_tr_ld_pc),
        .irq_mem_wr_tr(irq_mem_wr_tr), .irq_pc_clr(irq_pc_clr),
        .irq_sc_clr(irq_sc_clr), .ien(ien)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural state of the I/O unit. rt_phase counts
    // the interrupt-cycle step in progress (0 = none, 1..3 = RT0..RT2).
    bit       m_valid = 1'b0;
    bit       m_fgi, m_fgo, m_ien;
    int       rt_phase;
    bit [7:0] m_inpr, m_outr;

    // Values seen in the most recent cycle, for the directed checks.
    logic       obs_pc_inc, obs_ac_ld, obs_in_ready, obs_out_valid, obs_ien;
    logic       obs_int_active, obs_any_irq;
    logic [7:0] obs_inpr, obs_out_data;
    logic [4:0] obs_irq;

    task automatic model_reset();
        m_fgi = 0; m_fgo = OUTEN; m_ien = 0; rt_phase = 0;
        m_inpr = 0; m_outr = 0; m_valid = 1;
    endtask

    task automatic model_step();
        bit io_ok, inp, outp, arm_src, old_ien;
        if (!rst_n) begin
            model_reset();
            return;
        end
        io_ok   = io_exec && (rt_phase == 0);
        inp     = io_ok && ir_low[11];
        outp    = OUTEN && io_ok && ir_low[10];
        arm_src = m_fgi || (OUTEN && m_fgo);
        old_ien = m_ien;
        if (inp) m_fgi = 0;
        else if (in_valid && !m_fgi) begin m_fgi = 1; m_inpr = in_data; end
        if (outp) begin m_fgo = 0; m_outr = ac_low; end
        else if (OUTEN && out_ack) m_fgo = 1;
        if (io_ok && ir_low[6]) m_ien = 0;
        else if (io_ok && ir_low[7]) m_ien = 1;
        if (rt_phase == 3) begin m_ien = 0; rt_phase = 0; end
        else if (rt_phase != 0) rt_phase++;
        else if (instr_done && old_ien && arm_src) rt_phase = 1;
    endtask

    // One clock of stimulus: drive after the falling edge, compare just
    // before the rising edge, then advance the model at the rising edge.
    task automatic cyc(input bit rn, input bit ioe, input bit [11:0] ir, input bit idone,
                       input bit [7:0] ac, input bit iv, input bit [7:0] id, input bit oa);
        bit         io_ok, e_pc, e_ld;
        bit [4:0]   e_irq;
        @(negedge clk);
        rst_n = rn; io_exec = ioe; ir_low = ir; instr_done = idone;
        ac_low = ac; in_valid = iv; in_data = id; out_ack = oa;
        #1;
        obs_pc_inc = pc_inc; obs_ac_ld = ac_inpr_ld; obs_in_ready = in_ready;
        obs_out_valid = out_valid; obs_ien = ien; obs_int_active = int_active;
        obs_inpr = inpr; obs_out_data = out_data;
        obs_irq = {irq_ar_clr, irq_tr_ld_pc, irq_mem_wr_tr, irq_pc_clr, irq_sc_clr};
        obs_any_irq = |obs_irq;
        if (m_valid) begin
            io_ok = ioe && (rt_phase == 0);
            e_ld  = rn && io_ok && ir[11];
            e_pc  = rn && ((io_ok && ir[9] && m_fgi) ||
                           (OUTEN && io_ok && ir[8] && m_fgo) || rt_phase == 3);
            e_irq = !rn ? 5'b0 :
                    (rt_phase == 1) ? 5'b11000 :
                    (rt_phase == 2) ? 5'b00110 :
                    (rt_phase == 3) ? 5'b00001 : 5'b00000;
            check("in_ready",   in_ready,   !m_fgi);
            check("out_valid",  out_valid,  OUTEN && !m_fgo);
            check("out_data",   out_data,   OUTEN ? m_outr : 8'h00);
            check("inpr",       inpr,       m_inpr);
            check("ien",        ien,        m_ien);
            check("int_active", int_active, rt_phase != 0);
            check("ac_inpr_ld", ac_inpr_ld, e_ld);
            check("pc_inc",     pc_inc,     e_pc);
            check("irq_strobes", obs_irq,   e_irq);
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 12'h000, 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic io(input bit [11:0] ir, input bit [7:0] ac);
        cyc(1, 1, ir, 0, ac, 0, 8'h00, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; io_exec = 0; ir_low = 0; instr_done = 0; ac_low = 0;
        in_valid = 0; in_data = 0; out_ack = 0;

        // Reset and idle.
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        check("rst_in_ready", obs_in_ready, 1);
        check("rst_out_valid", obs_out_valid, 0);
        check("rst_ien", obs_ien, 0);
        check("rst_int_active", obs_int_active, 0);
        check("rst_out_data", obs_out_data, 8'h00);

        // Character in, SKI, INP.
        cyc(1, 0, 0, 0, 0, 1, 8'h41, 0);
        io(12'h200, 0);
        check("ski_taken", obs_pc_inc, 1);
        io(12'h800, 0);
        check("inp_ld", obs_ac_ld, 1);
        check("inp_inpr", obs_inpr, 8'h41);
        idle(1);
        check("inp_ready", obs_in_ready, 1);

`ifdef BC_OUTPUT_PORT_EN
        io(12'h400, 8'h5A);
        idle(1);
        check("out_valid_set", obs_out_valid, 1);
        check("out_data", obs_out_data, 8'h5A);
        io(12'h100, 0);
        check("sko_not_taken", obs_pc_inc, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("out_ack_clr", obs_out_valid, 0);
        io(12'h100, 0);
        check("sko_taken", obs_pc_inc, 1);
`endif

        // Interrupt cycle with FGI set.
        cyc(1, 0, 0, 0, 0, 1, 8'h41, 0);
        io(12'h080, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        check("irq_not_yet", obs_int_active, 0);
        idle(1);
        check("rt0_act", obs_int_active, 1);
        check("rt0_strb", obs_irq, 5'b11000);
        idle(1);
        check("rt1_act", obs_int_active, 1);
        check("rt1_strb", obs_irq, 5'b00110);
        idle(1);
        check("rt2_act", obs_int_active, 1);
        check("rt2_strb", obs_irq, 5'b00001);
        check("rt2_pc_inc", obs_pc_inc, 1);
        idle(1);
        check("rt_done_act", obs_int_active, 0);
        check("rt_done_ien", obs_ien, 0);

        // ION|IOF together, and a strobe while FGI is still set.
        io(12'h0C0, 0);
        cyc(1, 0, 0, 0, 0, 1, 8'h33, 0);
        idle(1);
        check("ion_iof_ien", obs_ien, 0);
        check("inpr_kept", obs_inpr, 8'h41);

        // Reset during RT1.
        io(12'h080, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_rt1_strb", obs_any_irq, 0);
        idle(1);
        check("rst_rt1_act", obs_int_active, 0);
        check("rst_rt1_ien", obs_ien, 0);
        check("rst_rt1_ov", obs_out_valid, 0);

`ifndef BC_OUTPUT_PORT_EN
        // IEN=1, FGI=0: no source, no interrupt.
        io(12'h080, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        check("no_src_irq", obs_int_active, 0);
        check("no_src_ien", obs_ien, 1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit [11:0] ir;
            bit        ioe;
            ioe = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) ir = 12'($urandom);
            else ir = 12'h040 << $urandom_range(0, 5);
            cyc(($urandom_range(0, 99) != 0), ioe, ir, ($urandom_range(0, 5) == 0),
                8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom),
                ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
